// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO controller.
package fifo_pkg;

   localparam int unsigned DEF_DATA_WIDTH = 8;
   localparam int unsigned DEF_ADDR_WIDTH = 10;

   // Bit positions inside the sticky error vector.
   localparam int unsigned ERR_OVF = 0;
   localparam int unsigned ERR_UDF = 1;
   localparam int unsigned ERR_W   = 2;

   function automatic int unsigned ptr_w(input int unsigned addr_width);
      return addr_width + 1;
   endfunction

endpackage

// File: rtl/fifo_ptr.sv
// FIFO pointer with increment enable and synchronous clear; MSB is the wrap bit.
module fifo_ptr
   import fifo_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_clr,
   input  logic                  i_en,
   output logic [ADDR_WIDTH-1:0] o_addr,
   output logic                  o_wrap
);

   localparam int unsigned PW = ptr_w(ADDR_WIDTH);

   logic [PW-1:0] ptr_q, ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      if (i_clr) begin
         ptr_d = '0;
      end else if (i_en) begin
         ptr_d = ptr_q + PW'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign o_addr = ptr_q[ADDR_WIDTH-1:0];
   assign o_wrap = ptr_q[PW-1];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Synchronous FIFO controller: pointers, occupancy, status flags and dual-port RAM drive.
module sync_fifo_ctrl
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int unsigned AFULL_LVL  = 2**ADDR_WIDTH - 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_flush,
   input  logic                  i_push,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   input  logic                  i_pop,
   output logic [DATA_WIDTH-1:0] o_rdata,
   output logic                  o_rvalid,
   output logic                  o_full,
   output logic                  o_empty,
   output logic                  o_afull,
   output logic [ADDR_WIDTH:0]   o_count,
   output logic                  o_ovf,
   output logic                  o_udf,
   output logic                  o_ram_wen,
   output logic [ADDR_WIDTH-1:0] o_ram_waddr,
   output logic [DATA_WIDTH-1:0] o_ram_wdata,
   output logic                  o_ram_ren,
   output logic [ADDR_WIDTH-1:0] o_ram_raddr,
   input  logic [DATA_WIDTH-1:0] i_ram_rdata
);

   localparam int unsigned  PW        = ptr_w(ADDR_WIDTH);
   localparam logic [PW-1:0] AFULL_CNT = PW'(AFULL_LVL);

   logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
   logic                  wr_wrap, rd_wrap;
   logic [PW-1:0]         wr_nxt, rd_nxt;
   logic                  push_ok, pop_ok;

   logic [PW-1:0]    count_q, count_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;
   logic             afull_q, afull_d;
   logic             rvalid_q, rvalid_d;
   logic [ERR_W-1:0] err_q, err_d;

   // Flush blocks both ports so nothing is written or read in that cycle.
   assign push_ok = i_push & ~full_q & ~i_flush;
   assign pop_ok  = i_pop & ~empty_q & ~i_flush;

   fifo_ptr #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_wr_ptr (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clr   (i_flush),
      .i_en    (push_ok),
      .o_addr  (wr_addr),
      .o_wrap  (wr_wrap)
   );

   fifo_ptr #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_rd_ptr (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clr   (i_flush),
      .i_en    (pop_ok),
      .o_addr  (rd_addr),
      .o_wrap  (rd_wrap)
   );

   // Post-edge pointer values, so the registered flags move on the same edge.
   assign wr_nxt = {wr_wrap, wr_addr} + PW'(push_ok);
   assign rd_nxt = {rd_wrap, rd_addr} + PW'(pop_ok);

   always_comb begin
      count_d  = count_q;
      full_d   = full_q;
      empty_d  = empty_q;
      afull_d  = afull_q;
      rvalid_d = 1'b0;
      err_d    = err_q;
      if (i_flush) begin
         count_d = '0;
         full_d  = 1'b0;
         empty_d = 1'b1;
         afull_d = 1'b0;
         err_d   = '0;
      end else begin
         count_d  = count_q + PW'(push_ok) - PW'(pop_ok);
         empty_d  = (wr_nxt == rd_nxt);
         full_d   = (wr_nxt[ADDR_WIDTH-1:0] == rd_nxt[ADDR_WIDTH-1:0]) &&
                    (wr_nxt[PW-1] != rd_nxt[PW-1]);
         afull_d  = (count_d >= AFULL_CNT);
         rvalid_d = pop_ok;
         if (i_push && full_q) begin
            err_d[ERR_OVF] = 1'b1;
         end
         if (i_pop && empty_q) begin
            err_d[ERR_UDF] = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         afull_q  <= 1'b0;
         rvalid_q <= 1'b0;
         err_q    <= '0;
      end else begin
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
         afull_q  <= afull_d;
         rvalid_q <= rvalid_d;
         err_q    <= err_d;
      end
   end

   assign o_ram_wen   = push_ok;
   assign o_ram_waddr = wr_addr;
   assign o_ram_wdata = i_wdata;
   assign o_ram_ren   = pop_ok;
   assign o_ram_raddr = rd_addr;

   assign o_rdata  = i_ram_rdata;
   assign o_rvalid = rvalid_q;
   assign o_full   = full_q;
   assign o_empty  = empty_q;
   assign o_afull  = afull_q;
   assign o_count  = count_q;
   assign o_ovf    = err_q[ERR_OVF];
   assign o_udf    = err_q[ERR_UDF];

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl with a registered-read RAM model and a read-data scoreboard.
module tb_sync_fifo_ctrl;

   localparam int unsigned DW = 8;
   localparam int unsigned AW = 3;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned AFULL = 4;

   logic          i_clk = 1'b0;
   logic          i_rst_n;
   logic          i_flush;
   logic          i_push;
   logic [DW-1:0] i_wdata;
   logic          i_pop;
   logic [DW-1:0] o_rdata;
   logic          o_rvalid;
   logic          o_full;
   logic          o_empty;
   logic          o_afull;
   logic [AW:0]   o_count;
   logic          o_ovf;
   logic          o_udf;
   logic          o_ram_wen;
   logic [AW-1:0] o_ram_waddr;
   logic [DW-1:0] o_ram_wdata;
   logic          o_ram_ren;
   logic [AW-1:0] o_ram_raddr;
   logic [DW-1:0] i_ram_rdata;

   int total = 0;
   int bad   = 0;

   // Reference model state
   int            mcount;
   bit            movf, mudf;
   logic [AW:0]   mwp, mrp;
   logic [DW-1:0] mq[$];
   logic [DW-1:0] sb[$];

   logic [DW-1:0] ram [DEPTH];

   sync_fifo_ctrl #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .AFULL_LVL  (AFULL)
   ) dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_flush     (i_flush),
      .i_push      (i_push),
      .i_wdata     (i_wdata),
      .i_pop       (i_pop),
      .o_rdata     (o_rdata),
      .o_rvalid    (o_rvalid),
      .o_full      (o_full),
      .o_empty     (o_empty),
      .o_afull     (o_afull),
      .o_count     (o_count),
      .o_ovf       (o_ovf),
      .o_udf       (o_udf),
      .o_ram_wen   (o_ram_wen),
      .o_ram_waddr (o_ram_waddr),
      .o_ram_wdata (o_ram_wdata),
      .o_ram_ren   (o_ram_ren),
      .o_ram_raddr (o_ram_raddr),
      .i_ram_rdata (i_ram_rdata)
   );

   always #5 i_clk = ~i_clk;

   always @(posedge i_clk) begin
      if (o_ram_wen) ram[o_ram_waddr] <= o_ram_wdata;
      if (o_ram_ren) i_ram_rdata <= ram[o_ram_raddr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      mq.delete();
      sb.delete();
      mcount = 0;
      movf   = 1'b0;
      mudf   = 1'b0;
      mwp    = '0;
      mrp    = '0;
   endtask

   task automatic check_state(input bit rv);
      chk("count", 32'(o_count), 32'(mcount));
      chk("empty", 32'(o_empty), 32'(mcount == 0));
      chk("full", 32'(o_full), 32'(mcount == DEPTH));
      chk("afull", 32'(o_afull), 32'(mcount >= AFULL));
      chk("ovf", 32'(o_ovf), 32'(movf));
      chk("udf", 32'(o_udf), 32'(mudf));
      chk("rvalid", 32'(o_rvalid), 32'(rv));
      if (o_rvalid === 1'b1) begin
         if (sb.size() == 0) chk("rdata_pending", 32'(sb.size()), 32'd1);
         else chk("rdata", 32'(o_rdata), 32'(sb.pop_front()));
      end
   endtask

   // Entered at posedge+1; drives one cycle and checks both the RAM drive and post-edge state.
   task automatic cycle(input bit push, input logic [DW-1:0] d, input bit pop, input bit flush);
      bit pk, pp;
      i_push  = push;
      i_wdata = d;
      i_pop   = pop;
      i_flush = flush;
      pk = push && !flush && (mcount != DEPTH);
      pp = pop && !flush && (mcount != 0);
      #3;
      chk("ram_wen", 32'(o_ram_wen), 32'(pk));
      chk("ram_ren", 32'(o_ram_ren), 32'(pp));
      chk("ram_waddr", 32'(o_ram_waddr), 32'(mwp[AW-1:0]));
      chk("ram_raddr", 32'(o_ram_raddr), 32'(mrp[AW-1:0]));
      if (pk) chk("ram_wdata", 32'(o_ram_wdata), 32'(d));
      if (flush) begin
         model_clear();
      end else begin
         if (push && !pk) movf = 1'b1;
         if (pop && !pp) mudf = 1'b1;
         if (pp) begin
            sb.push_back(mq.pop_front());
            mrp = mrp + 1'b1;
         end
         if (pk) begin
            mq.push_back(d);
            mwp = mwp + 1'b1;
         end
         mcount = mq.size();
      end
      @(posedge i_clk);
      #1;
      i_push  = 1'b0;
      i_pop   = 1'b0;
      i_flush = 1'b0;
      check_state(pp);
   endtask

   task automatic async_reset();
      #2;
      i_rst_n = 1'b0;
      #1;
      model_clear();
      check_state(1'b0);
      #3;
      i_rst_n = 1'b1;
      @(posedge i_clk);
      #1;
   endtask

   initial begin
      i_rst_n = 1'b0;
      i_flush = 1'b0;
      i_push  = 1'b0;
      i_pop   = 1'b0;
      i_wdata = '0;
      model_clear();
      repeat (2) @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;
      check_state(1'b0);

      // Pop on empty out of reset, then flush clears the sticky flag
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b1);

      // Basic ordering
      cycle(1'b1, 8'h11, 1'b0, 1'b0);
      cycle(1'b1, 8'h22, 1'b0, 1'b0);
      cycle(1'b1, 8'h33, 1'b0, 1'b0);
      repeat (3) cycle(1'b0, 8'h00, 1'b1, 1'b0);

      // Fill to full, overflow push, then push+pop while full
      for (int i = 0; i < 8; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
      cycle(1'b1, 8'h99, 1'b0, 1'b0);
      cycle(1'b1, 8'hAA, 1'b1, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b1);

      // Push+pop while empty, then sustained push+pop across wraps
      cycle(1'b1, 8'h40, 1'b1, 1'b0);
      for (int i = 1; i <= 20; i++) cycle(1'b1, 8'(8'h40 + i), 1'b1, 1'b0);

      // Flush together with a push
      cycle(1'b1, 8'hC1, 1'b0, 1'b0);
      cycle(1'b1, 8'hC2, 1'b0, 1'b0);
      cycle(1'b1, 8'hEE, 1'b0, 1'b1);

      // Asynchronous reset with a read in flight
      cycle(1'b1, 8'hD1, 1'b0, 1'b0);
      cycle(1'b1, 8'hD2, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      async_reset();
      cycle(1'b1, 8'h5A, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sync_fifo_ctrl.md
# sync_fifo_ctrl

Synchronous FIFO controller that sequences a dual-port RAM: it owns the write and read pointers, the occupancy count and the status flags, and drives the RAM's write and read ports from push/pop requests. Both RAM ports are clocked from the single FIFO clock. The RAM's registered read gives one cycle of read latency, which the controller reports through `o_rvalid`. It sits between a producer and a consumer on the same clock domain, with the RAM instantiated beside it in the enclosing wrapper.

## Interface
- `DATA_WIDTH`, default 8: word width.
- `ADDR_WIDTH`, default 10: RAM address width; depth = 2**ADDR_WIDTH.
- `AFULL_LVL`, default 2**ADDR_WIDTH-4: `o_afull` asserts when count >= this value.
- `i_clk`  in  1: single clock; all logic is on the rising edge.
- `i_rst_n`  in  1: reset, asynchronous and active-low.
- `i_flush`  in  1: synchronous clear of pointers, count and flags.
- `i_push`  in  1: write request.
- `i_wdata`  in  DATA_WIDTH: write data.
- `i_pop`  in  1: read request.
- `o_rdata`  out  DATA_WIDTH: read data, equal to `i_ram_rdata`; valid only while `o_rvalid`.
- `o_rvalid`  out  1: `o_rdata` holds the word for the pop accepted on the previous cycle.
- `o_full`, `o_empty`, `o_afull`  out  1: status flags.
- `o_count`  out  ADDR_WIDTH+1: occupancy, range 0..2**ADDR_WIDTH.
- `o_ovf`, `o_udf`  out  1: sticky error flags for a rejected push and a rejected pop.
- `o_ram_wen`  out  1: RAM write enable.
- `o_ram_waddr`  out  ADDR_WIDTH: RAM write address.
- `o_ram_wdata`  out  DATA_WIDTH: RAM write data.
- `o_ram_ren`  out  1: RAM read enable.
- `o_ram_raddr`  out  ADDR_WIDTH: RAM read address.
- `i_ram_rdata`  in  DATA_WIDTH: registered RAM read data.

## Operation
- Pointers: `wr_ptr` and `rd_ptr` are ADDR_WIDTH+1 bits each. The low bits are the RAM address; the MSB is the wrap bit.
- Empty: `wr_ptr == rd_ptr`.
- Full: the address bits are equal and the wrap bits differ.
- Accept: `push_ok = i_push & ~o_full` and `pop_ok = i_pop & ~o_empty`. Both are evaluated on the pre-edge state.
- RAM drive is combinational:
  - `o_ram_wen = push_ok`, `o_ram_waddr = wr_ptr[ADDR_WIDTH-1:0]`, `o_ram_wdata = i_wdata`.
  - `o_ram_ren = pop_ok`, `o_ram_raddr = rd_ptr[ADDR_WIDTH-1:0]`.
- On each edge:
  - `wr_ptr += push_ok` and `rd_ptr += pop_ok`, both modulo 2**(ADDR_WIDTH+1).
  - `count += push_ok - pop_ok`.
  - `o_rvalid <= pop_ok`.
- Push and pop together:
  - When neither full nor empty, both are accepted and the count is unchanged.
  - When full, only the pop is accepted and the push sets `o_ovf`. The push is not retried.
  - When empty, only the push is accepted and the pop sets `o_udf`. There is no fall-through.
- Error flags: `o_ovf` and `o_udf` stay set until reset or `i_flush`. A rejected request changes no pointer.
- Flush:
  - `i_flush` has priority over push and pop in the same cycle.
  - That cycle drives `o_ram_wen` = 0 and `o_ram_ren` = 0.
  - Next cycle: pointers = 0, count = 0, `o_empty` = 1, `o_rvalid` = 0, both error flags = 0.
  - RAM contents are not cleared.
- Flags `o_full`, `o_empty`, `o_afull` and `o_count` are registered, and each updates on the same edge as the pointers.

## Timing
- Reset values: `o_empty` = 1; `o_full`, `o_afull`, `o_rvalid`, `o_ovf` and `o_udf` = 0; `o_count` = 0; pointers = 0.
- Reset asserted mid-operation clears everything immediately and asynchronously. Any in-flight `o_rvalid` is dropped.
- Write to visible: a push at edge N gives `o_empty` = 0 after edge N, so a pop is legal in cycle N+1.
- Read latency: a pop accepted in cycle N gives `o_rvalid` = 1 in cycle N+1, with `o_rdata` carrying that word.
- Throughput: one push and one pop every cycle, sustained.
- Wrap-around: the address rolls from 2**ADDR_WIDTH-1 to 0 and the wrap bit toggles. No bubble is inserted.

## Structure
- Shared package `fifo_pkg`:
  - pointer width function `ptr_w(ADDR_WIDTH) = ADDR_WIDTH+1`;
  - default width constants;
  - error-flag bit indices.
- Natural sub-module `fifo_ptr`: one instance each for write and read. Each holds a pointer with enable and synchronous clear, and outputs the address and wrap bit.
- Flags, count and the RAM port drive stay in the top module.

## Test plan
- Reset, then push 0x11, 0x22, 0x33, then pop three times:
  - `o_rvalid` pulses in the cycle after each pop, with `o_rdata` = 0x11, 0x22, 0x33 in order;
  - `o_empty` returns to 1 after the third pop;
  - `o_count` reads 0, 1, 2, 3, 2, 1, 0.
- With ADDR_WIDTH=3, push 8 words 0x00..0x07:
  - `o_full` = 1 and `o_count` = 8; `o_afull` asserted from count 4 (AFULL_LVL=4);
  - a 9th push gives `o_ovf` = 1, the pointer is unchanged and `o_ram_wen` = 0.
- Pop on empty at reset: `o_udf` = 1, `o_ram_ren` = 0, `o_rvalid` stays 0, and `o_count` stays 0.
- Simultaneous push and pop:
  - when full: pop accepted, push rejected, `o_count` goes 8 to 7, `o_ovf` = 1;
  - when empty: `o_count` goes 0 to 1 and `o_udf` = 1.
- Continuous push and pop for 20 cycles at ADDR_WIDTH=3:
  - data comes out in order across two wrap-arounds;
  - `o_count` stays constant at 1 after the first push.
- Mid-stream `i_flush`:
  - when `i_flush` is asserted together with a push, that push is ignored;
  - next cycle: `o_empty` = 1, `o_count` = 0, error flags = 0.
- Mid-stream asynchronous reset: the same cleared state is required without waiting for a clock edge.
